wide_add_sequencer: RTL

Multi-word adder sequencer that sits directly upstream of the team's 32-bit carry-lookahead adder `cla32bit` (ports a, b, cin, sum, cout) and drives it one word per clock.
- Latches two WORDS×32-bit operands plus a carry-in on a start pulse.
- Feeds the operands to one internal `cla32bit` instance least-significant word first, chaining the carry through a register.
- Presents the full-width sum, carry-out and signed-overflow flag with a one-cycle done pulse.
- Gives wide (default 128-bit) additions while reusing the single 32-bit CLA datapath.

---
 rtl/wide_add_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - multi-word adder sequencer around a single 32-bit CLA

// 32-bit carry-lookahead adder: eight 4-bit lookahead groups, carry rippled between groups
module cla32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Lookahead carries inside each nibble group, group carry-in taken from the previous group
  always_comb begin
    c = '0;
    c[0] = cin;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [32*WORDS-1:0]   a_in,
  input  logic [32*WORDS-1:0]   b_in,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [32*WORDS-1:0]   sum_out,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W  = 32 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic          carry_r;
  logic [IW-1:0] idx;
  logic [31:0]   a_word;
  logic [31:0]   b_word;
  logic [31:0]   cla_sum;
  logic          cla_cout;
  logic          msb_cin;

  cla32bit u_cla (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry_r),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // Select the operand words for the current index and merge the CLA result into the accumulator
  always_comb begin
    a_word   = '0;
    b_word   = '0;
    acc_next = acc;
    for (int w = 0; w < WORDS; w++) begin
      if (idx == IW'(w)) begin
        a_word = a_reg[32*w +: 32];
        b_word = b_reg[32*w +: 32];
        acc_next[32*w +: 32] = cla_sum;
      end
    end
  end

  // Carry into the top bit of the top word, used for signed overflow
  assign msb_cin = a_word[31] ^ b_word[31] ^ cla_sum[31];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: start is only honoured outside RUN
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (idx == LAST) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Operand latch, word-serial accumulation and result publication
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg   <= a_in;
            b_reg   <= b_in;
            carry_r <= cin;
            idx     <= '0;
          end
        end
        RUN: begin
          acc     <= acc_next;
          carry_r <= cla_cout;
          if (idx == LAST) begin
            sum_out <= acc_next;
            cout    <= cla_cout;
            ovf     <= msb_cin ^ cla_cout;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
